mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, synchronous-read memory between the instruction-fetch path (read-only) and the data-memory path (read/write) of the 5-stage pipeline. The data port has priority, and a starvation guard bounds fetch latency. It tracks which requester owns the outstanding read and routes the one-cycle-late read data back with a response pulse. It sits between `Instruction_Memory`/`mem_Rsync` users (F and M stages) and a unified memory macro.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data word width
- `STARVE_LIMIT`, 4, consecutive fetch denials before fetch is forced to win; legal range ≥1
- `clk_i` in 1: clock
- `reset_i` in 1: asynchronous, active-high reset
- `if_req_valid_i` in 1: fetch read request
- `if_req_ready_o` out 1: fetch request granted this cycle
- `if_addr_i` in ADDR_W: fetch address
- `if_flush_i` in 1: pipeline flush; kills fetch grant and fetch response
- `if_rsp_valid_o` out 1: fetch read data valid
- `if_rsp_data_o` out DATA_W: fetch read data
- `dm_req_valid_i` in 1: data request
- `dm_req_ready_o` out 1: data request granted this cycle
- `dm_we_i` in 1: 1 = write, 0 = read
- `dm_addr_i` in ADDR_W: data address
- `dm_wdata_i` in DATA_W: write data
- `dm_rsp_valid_o` out 1: data read data valid (reads only)
- `dm_rsp_data_o` out DATA_W: data read data
- `mem_wr_valid_o` out 1, `mem_wr_addr_o` out ADDR_W, `mem_wr_data_o` out DATA_W: memory write port
- `mem_rd_valid_o` out 1, `mem_rd_addr_o` out ADDR_W: memory read request
- `mem_rd_data_i` in DATA_W: memory read data, valid the cycle after `mem_rd_valid_o`

## Operation
- At most one grant per cycle. A transfer occurs when valid and ready are both high in the same cycle.
- Grant rule (combinational on current inputs and state):
  - Only DM valid → DM.
  - Only IF valid and `if_flush_i`=0 → IF.
  - Both valid → DM, unless `starve_cnt == STARVE_LIMIT`, in which case IF (when `if_flush_i`=0).
- `if_flush_i`=1 forces `if_req_ready_o`=0. The DM port is unaffected.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`):
  - +1 on each cycle where IF is valid, not flushed, and DM is granted.
  - Cleared when IF is granted, or when `if_req_valid_i`=0, or on flush.
  - Saturates at `STARVE_LIMIT`.
- Granted DM write: drive `mem_wr_*` in that cycle. The write completes at that edge; no response.
- Granted read (IF, or DM with `dm_we_i`=0): drive `mem_rd_valid_o`/`mem_rd_addr_o`. Register `owner` ← OWN_IF/OWN_DM, else OWN_NONE.
- Response cycle: `owner`=OWN_DM → `dm_rsp_valid_o`=1. `owner`=OWN_IF → `if_rsp_valid_o` = ~`if_flush_i`.
- Response data outputs pass `mem_rd_data_i` through. They are meaningful only while the corresponding rsp_valid is high.
- No backpressure on responses: requesters must capture them in the response cycle.
- Unselected `mem_*` address/data outputs are driven to 0.

## Timing
- Grant: 0-cycle combinational. Read latency: exactly 1 cycle from grant to rsp_valid.
- Back-to-back reads sustain 1 per cycle. A response for grant N and a new grant N+1 coexist in the same cycle.
- Reset (async assert, sync-safe deassert): `owner`=OWN_NONE, `starve_cnt`=0.
- While `reset_i`=1, all ready, rsp_valid and `mem_*_valid` outputs are 0; data/address outputs are 0.
- Reset mid-operation: any outstanding read is dropped, and no rsp_valid follows reset release.
- Flush in the response cycle of an IF read suppresses that response. A flush in the grant cycle blocks the grant itself.
- A DM read outstanding across a flush still responds.
- `STARVE_LIMIT`=1: the ports alternate under continuous contention.

## Structure
- Shared package `mem_arb_pkg`:
  - `owner_e` enum {OWN_NONE, OWN_IF, OWN_DM}
  - Default `ADDR_W`/`DATA_W` localparams
- State: the `owner` register plus `starve_cnt`; the grant logic is a single combinational block.
- No sub-module is natural; the block is one module.

## Test plan
- DM write addr 0x10 data 0xDEADBEEF with IF idle → `mem_wr_valid_o`=1 same cycle, no rsp. A following DM read of 0x10 → `dm_rsp_valid_o`=1 one cycle later with 0xDEADBEEF.
- IF reads 0x0,0x4,0x8 back-to-back, DM idle → grants in cycles 0–2, `if_rsp_valid_o` in cycles 1–3 with matching data.
- Both valid continuously, STARVE_LIMIT=4 → DM granted 4 cycles, IF granted on the 5th, pattern repeats (4:1).
- IF read granted in cycle N, `if_flush_i`=1 in N+1 → `if_rsp_valid_o`=0 in N+1, `if_req_ready_o`=0 in N+1. A DM read granted in N+1 responds in N+2.
- DM read granted, `reset_i` pulsed before the response edge → `dm_rsp_valid_o` stays 0, `starve_cnt` and `owner` return to 0/OWN_NONE.
- STARVE_LIMIT=1 with both valid → grants alternate DM, IF, DM, IF.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner encoding and default widths for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sync-read memory between fetch and data ports, data first with a starvation guard
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              if_req_valid_i,
  output logic              if_req_ready_o,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_rsp_valid_o,
  output logic [DATA_W-1:0] if_rsp_data_o,
  input  logic              dm_req_valid_i,
  output logic              dm_req_ready_o,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_rsp_valid_o,
  output logic [DATA_W-1:0] dm_rsp_data_o,
  output logic              mem_wr_valid_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              mem_rd_valid_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  owner_e owner, owner_nx;
  logic [CW-1:0] starve_cnt, starve_nx;
  logic if_ok, starved, gnt_if, gnt_dm, rd_dm, wr_dm;
  always_comb begin
    if_ok          = if_req_valid_i & ~if_flush_i & ~reset_i;
    starved        = starve_cnt == CW'(STARVE_LIMIT);
    gnt_if         = if_ok & (~dm_req_valid_i | starved);
    gnt_dm         = dm_req_valid_i & ~reset_i & ~gnt_if;
    wr_dm          = gnt_dm & dm_we_i;
    rd_dm          = gnt_dm & ~dm_we_i;
    owner_nx       = gnt_if ? OWN_IF : rd_dm ? OWN_DM : OWN_NONE;
    // an ungranted, unflushed fetch implies the data port won this cycle
    starve_nx      = (~if_ok | gnt_if) ? '0 : starved ? starve_cnt : starve_cnt + CW'(1);
    if_req_ready_o = gnt_if;
    dm_req_ready_o = gnt_dm;
    mem_wr_valid_o = wr_dm;
    mem_wr_addr_o  = wr_dm ? dm_addr_i : '0;
    mem_wr_data_o  = wr_dm ? dm_wdata_i : '0;
    mem_rd_valid_o = gnt_if | rd_dm;
    mem_rd_addr_o  = gnt_if ? if_addr_i : rd_dm ? dm_addr_i : '0;
    if_rsp_valid_o = (owner == OWN_IF) & ~if_flush_i & ~reset_i;
    dm_rsp_valid_o = (owner == OWN_DM) & ~reset_i;
    if_rsp_data_o  = reset_i ? '0 : mem_rd_data_i;
    dm_rsp_data_o  = reset_i ? '0 : mem_rd_data_i;
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      owner      <= owner_nx;
      starve_cnt <= starve_nx;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, responses, flush, reset and starvation for two limits
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset_i, if_req_valid, if_flush, dm_req_valid, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, rd_data;
  logic if_ready, if_rsp_valid, dm_ready, dm_rsp_valid, wr_valid, rd_valid;
  logic [31:0] if_rsp_data, dm_rsp_data, wr_addr, wr_data, rd_addr;
  logic b_if_ready, b_if_rsp_valid, b_dm_ready, b_dm_rsp_valid, b_wr_valid, b_rd_valid;
  logic [31:0] b_if_rsp_data, b_dm_rsp_data, b_wr_addr, b_wr_data, b_rd_addr;
  logic [31:0] wmem [64];
  logic [63:0] wv = '0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_valid_i(if_req_valid), .if_req_ready_o(if_ready), .if_addr_i(if_addr),
    .if_flush_i(if_flush), .if_rsp_valid_o(if_rsp_valid), .if_rsp_data_o(if_rsp_data),
    .dm_req_valid_i(dm_req_valid), .dm_req_ready_o(dm_ready), .dm_we_i(dm_we),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rsp_valid_o(dm_rsp_valid),
    .dm_rsp_data_o(dm_rsp_data), .mem_wr_valid_o(wr_valid), .mem_wr_addr_o(wr_addr),
    .mem_wr_data_o(wr_data), .mem_rd_valid_o(rd_valid), .mem_rd_addr_o(rd_addr),
    .mem_rd_data_i(rd_data)
  );

  mem_port_arbiter #(.STARVE_LIMIT(1)) dut1 (
    .clk_i(clk), .reset_i(reset_i),
    .if_req_valid_i(if_req_valid), .if_req_ready_o(b_if_ready), .if_addr_i(if_addr),
    .if_flush_i(if_flush), .if_rsp_valid_o(b_if_rsp_valid), .if_rsp_data_o(b_if_rsp_data),
    .dm_req_valid_i(dm_req_valid), .dm_req_ready_o(b_dm_ready), .dm_we_i(dm_we),
    .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata), .dm_rsp_valid_o(b_dm_rsp_valid),
    .dm_rsp_data_o(b_dm_rsp_data), .mem_wr_valid_o(b_wr_valid), .mem_wr_addr_o(b_wr_addr),
    .mem_wr_data_o(b_wr_data), .mem_rd_valid_o(b_rd_valid), .mem_rd_addr_o(b_rd_addr),
    .mem_rd_data_i(rd_data)
  );

  // memory macro model: unwritten word i reads as 0x1000+i
  always @(posedge clk) begin
    if (wr_valid) begin
      wmem[wr_addr[7:2]] <= wr_data;
      wv[wr_addr[7:2]]   <= 1'b1;
    end
    if (rd_valid) rd_data <= wv[rd_addr[7:2]] ? wmem[rd_addr[7:2]] : 32'h1000 + 32'(rd_addr[7:2]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; if_flush = 1'b0; dm_we = 1'b0;
    if_req_valid = 1'b1; dm_req_valid = 1'b1;
    if_addr = 32'h4; dm_addr = 32'h8; dm_wdata = 32'h0;
    #2;
    chk("rst_if_ready", {31'b0, if_ready}, 0);
    chk("rst_dm_ready", {31'b0, dm_ready}, 0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rsp_valid", {30'b0, if_rsp_valid, dm_rsp_valid}, 0);
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    // DM write then read-back
    dm_req_valid = 1'b1; dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_ready", {31'b0, dm_ready}, 1);
    chk("wr_valid", {31'b0, wr_valid}, 1);
    chk("wr_addr", wr_addr, 32'h10);
    chk("wr_data", wr_data, 32'hDEADBEEF);
    chk("wr_no_rd", {31'b0, rd_valid}, 0);
    tick();
    dm_we = 1'b0;
    #1;
    chk("wr_no_rsp", {31'b0, dm_rsp_valid}, 0);
    chk("dmrd_rd_valid", {31'b0, rd_valid}, 1);
    chk("dmrd_rd_addr", rd_addr, 32'h10);
    chk("dmrd_no_wr", {31'b0, wr_valid}, 0);
    chk("dmrd_wr_addr0", wr_addr, 0);
    tick();
    dm_req_valid = 1'b0;
    #1;
    chk("dmrd_rsp_valid", {31'b0, dm_rsp_valid}, 1);
    chk("dmrd_rsp_data", dm_rsp_data, 32'hDEADBEEF);
    chk("dmrd_no_if_rsp", {31'b0, if_rsp_valid}, 0);
    // back-to-back fetches
    tick();
    if_req_valid = 1'b1; if_addr = 32'h0;
    #1;
    chk("if0_ready", {31'b0, if_ready}, 1);
    chk("if0_rd_addr", rd_addr, 32'h0);
    tick();
    if_addr = 32'h4;
    #1;
    chk("if1_ready", {31'b0, if_ready}, 1);
    chk("if0_rsp_valid", {31'b0, if_rsp_valid}, 1);
    chk("if0_rsp_data", if_rsp_data, 32'h1000);
    tick();
    if_addr = 32'h8;
    #1;
    chk("if1_rsp_data", if_rsp_data, 32'h1001);
    chk("if2_rd_addr", rd_addr, 32'h8);
    tick();
    if_req_valid = 1'b0;
    #1;
    chk("if2_rsp_valid", {31'b0, if_rsp_valid}, 1);
    chk("if2_rsp_data", if_rsp_data, 32'h1002);
    chk("if_idle_ready", {31'b0, if_ready}, 0);
    tick();
    #1;
    chk("if_idle_rsp", {31'b0, if_rsp_valid}, 0);
    // continuous contention: 4:1 for limit 4, alternating for limit 1
    tick();
    if_req_valid = 1'b1; if_addr = 32'hC;
    dm_req_valid = 1'b1; dm_addr = 32'h20;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_if_ready_%0d", i), {31'b0, if_ready}, (i % 5 == 4) ? 1 : 0);
      chk($sformatf("cont_dm_ready_%0d", i), {31'b0, dm_ready}, (i % 5 == 4) ? 0 : 1);
      chk($sformatf("lim1_if_ready_%0d", i), {31'b0, b_if_ready}, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("lim1_dm_ready_%0d", i), {31'b0, b_dm_ready}, (i % 2 == 1) ? 0 : 1);
      tick();
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    tick();
    // flush in the response cycle of a fetch
    if_req_valid = 1'b1; if_addr = 32'h4;
    #1;
    chk("fl_if_grant", {31'b0, if_ready}, 1);
    tick();
    if_flush = 1'b1; dm_req_valid = 1'b1; dm_addr = 32'h10;
    #1;
    chk("fl_if_rsp", {31'b0, if_rsp_valid}, 0);
    chk("fl_if_ready", {31'b0, if_ready}, 0);
    chk("fl_dm_ready", {31'b0, dm_ready}, 1);
    chk("fl_rd_addr", rd_addr, 32'h10);
    tick();
    if_flush = 1'b0; if_req_valid = 1'b0; dm_addr = 32'h8;
    #1;
    chk("fl_dm_rsp", {31'b0, dm_rsp_valid}, 1);
    chk("fl_dm_data", dm_rsp_data, 32'hDEADBEEF);
    chk("fl_no_if_rsp", {31'b0, if_rsp_valid}, 0);
    chk("fl2_dm_ready", {31'b0, dm_ready}, 1);
    tick();
    dm_req_valid = 1'b0; if_flush = 1'b1;
    #1;
    chk("fl2_dm_rsp", {31'b0, dm_rsp_valid}, 1);
    chk("fl2_dm_data", dm_rsp_data, 32'h1002);
    tick();
    if_flush = 1'b0;
    // reset mid-operation drops the read and clears the starvation count
    if_req_valid = 1'b1; if_addr = 32'hC;
    dm_req_valid = 1'b1; dm_addr = 32'h10;
    #1;
    chk("rm_dm_ready0", {31'b0, dm_ready}, 1);
    tick();
    #1;
    chk("rm_dm_ready1", {31'b0, dm_ready}, 1);
    reset_i = 1'b1;
    #1;
    chk("rm_dm_ready_rst", {31'b0, dm_ready}, 0);
    chk("rm_rd_valid_rst", {31'b0, rd_valid}, 0);
    chk("rm_rsp_rst", {30'b0, if_rsp_valid, dm_rsp_valid}, 0);
    tick();
    reset_i = 1'b0;
    #1;
    chk("rm_no_rsp", {31'b0, dm_rsp_valid}, 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rm_if_ready_%0d", i), {31'b0, if_ready}, (i == 4) ? 1 : 0);
      tick();
      #1;
    end
    if_req_valid = 1'b0; dm_req_valid = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
